// File: rtl/divider.sv
// -----------------------------------------------------------------------------
// divider
//
// Iterative restoring divider sharing the HI/LO result convention of the
// single-cycle multiplier: quotient in LO, remainder in HI. One quotient bit
// is produced per clock. A request is accepted only in IDLE. The result
// appears, with a one-cycle done pulse, width+1 edges after the accepting
// edge. HI/LO hold their value until the next operation completes.
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset (aborts any operation)
//   in_A       dividend, sampled on the accepting edge only
//   in_B       divisor, sampled on the accepting edge only
//   signed_op  1 = two's-complement divide, 0 = unsigned divide
//   start      divide request, honoured only while idle
//   busy       high while an operation is in progress
//   done       one-cycle pulse when out_hi/out_lo have been written
//   out_hi     remainder register (HI)
//   out_lo     quotient register (LO)
// -----------------------------------------------------------------------------
module divider #(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] in_A,
  input  logic [width-1:0] in_B,
  input  logic             signed_op,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [width-1:0] out_hi,
  output logic [width-1:0] out_lo
);

  localparam int CNT_W = $clog2(width + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t state;

  // Working registers. dvd starts as the dividend magnitude and is shifted
  // left each step while quotient bits enter at the bottom, so it ends up
  // holding the unsigned quotient.
  logic [width-1:0] dvd;
  logic [width-1:0] divisor;
  logic [width-1:0] rem;
  logic [CNT_W-1:0] cnt;
  logic             q_neg;
  logic             r_neg;
  logic             div_zero;

  // Signed views of the operands, used only for sign and magnitude extraction.
  logic signed [width-1:0] a_s;
  logic signed [width-1:0] b_s;

  assign a_s = in_A;
  assign b_s = in_B;

  // Two's-complement negate when requested.
  function automatic logic [width-1:0] cond_negate(input logic [width-1:0] v,
                                                   input logic             neg);
    return neg ? (~v + width'(1)) : v;
  endfunction

  // Magnitude as an unsigned value. The most-negative input maps to
  // 2^(width-1), which still fits in width unsigned bits.
  function automatic logic [width-1:0] magnitude(input logic signed [width-1:0] v,
                                                 input logic                    is_signed);
    return (is_signed && (v < 0)) ? cond_negate(v, 1'b1) : v;
  endfunction

  // One restoring step. The shifted partial remainder needs width+1 bits.
  // When the trial subtraction succeeds, the true difference is below the
  // divisor, so the low width bits of a modular subtract are exact.
  logic [width:0]   shifted;
  logic             trial_ok;
  logic [width-1:0] trial;

  assign shifted  = {rem, dvd[width-1]};
  assign trial_ok = (shifted >= {1'b0, divisor});
  assign trial    = shifted[width-1:0] - divisor;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      out_hi   <= '0;
      out_lo   <= '0;
      dvd      <= '0;
      divisor  <= '0;
      rem      <= '0;
      cnt      <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        // Accept: latch magnitudes and result signs.
        IDLE: begin
          if (start) begin
            dvd      <= magnitude(a_s, signed_op);
            divisor  <= magnitude(b_s, signed_op);
            q_neg    <= signed_op & (in_A[width-1] ^ in_B[width-1]);
            r_neg    <= signed_op & in_A[width-1];
            div_zero <= (in_B == '0);
            rem      <= '0;
            cnt      <= CNT_W'(width);
            busy     <= 1'b1;
            state    <= RUN;
          end
        end

        // Iterate: one quotient bit per edge.
        RUN: begin
          rem <= trial_ok ? trial : shifted[width-1:0];
          dvd <= {dvd[width-2:0], trial_ok};
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= FINISH;
          end
        end

        // Write back: apply signs and publish.
        // With a zero divisor every trial succeeds, so the remainder
        // reconstructs |A|; restoring A's sign yields the original dividend.
        // Only the quotient needs forcing to all ones.
        FINISH: begin
          out_lo <= div_zero ? '1 : cond_negate(dvd, q_neg);
          out_hi <= cond_negate(rem, r_neg);
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider.sv
// -----------------------------------------------------------------------------
// tb_divider
//
// Self-checking bench for divider. Each scenario task drives its own stimulus
// and compares results against constants or a plain-arithmetic reference
// model. Outputs are sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_divider;

  localparam int W   = 32;
  localparam int LAT = W + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in_A;
  logic [W-1:0] in_B;
  logic         signed_op;
  logic         start;
  logic         busy;
  logic         done;
  logic [W-1:0] out_hi;
  logic [W-1:0] out_lo;

  int checks   = 0;
  int failures = 0;

  divider #(.width(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_A      (in_A),
    .in_B      (in_B),
    .signed_op (signed_op),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .out_hi    (out_hi),
    .out_lo    (out_lo)
  );

  always #5 clk = ~clk;

  // Reference model. Division by zero returns all ones and the dividend.
  // Otherwise the result comes from 64-bit arithmetic: truncating quotient,
  // and a remainder that takes the dividend's sign.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic s,
                                output logic [W-1:0] q, output logic [W-1:0] r);
    longint          sa, sb;
    longint unsigned ua, ub;
    if (b == '0) begin
      q = '1;
      r = a;
    end else if (s) begin
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
      q  = W'(sa / sb);
      r  = W'(sa % sb);
    end else begin
      ua = longint'(a);
      ub = longint'(b);
      q  = W'(ua / ub);
      r  = W'(ua % ub);
    end
  endfunction

  // Present a request. When now=1 it is driven in the current cycle;
  // otherwise it is driven at the next falling edge. The task returns 1 ns
  // after the accepting edge, then scrambles the operands.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input bit now);
    if (!now) @(negedge clk);
    in_A      = a;
    in_B      = b;
    signed_op = s;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    in_A      = $urandom;
    in_B      = $urandom;
    signed_op = ~s;
  endtask

  // Wait for done, counting edges from the accepting edge. Also counts the
  // cycles in which busy is seen, and whether HI/LO stay unchanged before done.
  task automatic wait_done(input int n0, output int lat, output int busy_cnt,
                           output bit held);
    logic [W-1:0] lo0;
    logic [W-1:0] hi0;
    lo0      = out_lo;
    hi0      = out_hi;
    lat      = n0;
    busy_cnt = busy ? 1 : 0;
    held     = 1'b1;
    while (lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) break;
      if (busy) busy_cnt++;
      if (out_lo !== lo0 || out_hi !== hi0) held = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    start     = 1'b1;
    in_A      = 32'd10;
    in_B      = 32'd3;
    signed_op = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
    checks++; if (out_hi !== '0) begin failures++; $display("FAIL reset_hi got=%h want=0", out_hi); end
    checks++; if (out_lo !== '0) begin failures++; $display("FAIL reset_lo got=%h want=0", out_lo); end
    @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_no_accept busy=%b want=0", busy); end
  endtask

  task automatic test_unsigned();
    int lat, bc;
    bit held;
    start_op(32'd100, 32'd7, 1'b0, 1'b0);
    wait_done(0, lat, bc, held);
    checks++; if (lat !== LAT) begin failures++; $display("FAIL udiv_latency got=%0d want=%0d", lat, LAT); end
    checks++; if (bc !== LAT) begin failures++; $display("FAIL udiv_busy_cycles got=%0d want=%0d", bc, LAT); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL udiv_busy_at_done got=%b want=0", busy); end
    checks++; if (out_lo !== 32'd14) begin failures++; $display("FAIL udiv_lo got=%0d want=14", out_lo); end
    checks++; if (out_hi !== 32'd2) begin failures++; $display("FAIL udiv_hi got=%0d want=2", out_hi); end
    checks++; if (held !== 1'b1) begin failures++; $display("FAIL udiv_no_partial_update got=%b want=1", held); end
    @(posedge clk);
    #1;
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL udiv_done_one_cycle got=%b want=0", done); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_lo !== 32'd14 || out_hi !== 32'd2) begin
      failures++; $display("FAIL udiv_hold got=%0d/%0d want=14/2", out_lo, out_hi);
    end
  endtask

  task automatic test_signed();
    logic [W-1:0] ta [3] = '{32'hFFFF_FFF9, 32'h0000_0007, 32'hFFFF_FFF9};
    logic [W-1:0] tb [3] = '{32'h0000_0002, 32'hFFFF_FFFE, 32'h0000_0002};
    logic         ts [3] = '{1'b1, 1'b1, 1'b0};
    logic [W-1:0] tq [3] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h7FFF_FFFC};
    logic [W-1:0] tr [3] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001};
    int lat, bc;
    bit held;
    for (int i = 0; i < 3; i++) begin
      start_op(ta[i], tb[i], ts[i], 1'b0);
      wait_done(0, lat, bc, held);
      checks++; if (out_lo !== tq[i]) begin failures++; $display("FAIL sign_case%0d_lo got=%h want=%h", i, out_lo, tq[i]); end
      checks++; if (out_hi !== tr[i]) begin failures++; $display("FAIL sign_case%0d_hi got=%h want=%h", i, out_hi, tr[i]); end
    end
  endtask

  task automatic test_div_zero();
    int lat, bc;
    bit held;
    for (int m = 0; m < 2; m++) begin
      start_op(32'h0000_1234, 32'h0, m[0], 1'b0);
      wait_done(0, lat, bc, held);
      checks++; if (lat !== LAT) begin failures++; $display("FAIL dz_mode%0d_latency got=%0d want=%0d", m, lat, LAT); end
      checks++; if (out_lo !== 32'hFFFF_FFFF) begin failures++; $display("FAIL dz_mode%0d_lo got=%h want=ffffffff", m, out_lo); end
      checks++; if (out_hi !== 32'h0000_1234) begin failures++; $display("FAIL dz_mode%0d_hi got=%h want=00001234", m, out_hi); end
    end
    start_op(32'hFFFF_8000, 32'h0, 1'b1, 1'b0);
    wait_done(0, lat, bc, held);
    checks++; if (out_lo !== 32'hFFFF_FFFF || out_hi !== 32'hFFFF_8000) begin
      failures++; $display("FAIL dz_negative got=%h/%h want=ffffffff/ffff8000", out_lo, out_hi);
    end
  endtask

  task automatic test_overflow();
    int lat, bc;
    bit held;
    start_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
    wait_done(0, lat, bc, held);
    checks++; if (out_lo !== 32'h8000_0000) begin failures++; $display("FAIL ovf_lo got=%h want=80000000", out_lo); end
    checks++; if (out_hi !== 32'h0) begin failures++; $display("FAIL ovf_hi got=%h want=0", out_hi); end
  endtask

  task automatic test_reject();
    int lat, bc;
    bit held;
    start_op(32'd1000, 32'd3, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    in_A      = 32'd77;
    in_B      = 32'd0;
    signed_op = 1'b1;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(5, lat, bc, held);
    checks++; if (lat !== LAT) begin failures++; $display("FAIL reject_latency got=%0d want=%0d", lat, LAT); end
    checks++; if (out_lo !== 32'd333 || out_hi !== 32'd1) begin
      failures++; $display("FAIL reject_result got=%0d/%0d want=333/1", out_lo, out_hi);
    end
    @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reject_not_queued busy=%b want=0", busy); end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    bit held;
    logic [W-1:0] q, r;
    start_op(32'd123456, 32'd789, 1'b0, 1'b0);
    wait_done(0, lat, bc, held);
    model(32'd123456, 32'd789, 1'b0, q, r);
    checks++; if (out_lo !== q || out_hi !== r) begin
      failures++; $display("FAIL b2b_first got=%0d/%0d want=%0d/%0d", out_lo, out_hi, q, r);
    end
    start_op(32'd50, 32'd5, 1'b0, 1'b1);
    wait_done(0, lat, bc, held);
    checks++; if (lat !== LAT) begin failures++; $display("FAIL b2b_latency got=%0d want=%0d", lat, LAT); end
    checks++; if (held !== 1'b1) begin failures++; $display("FAIL b2b_hold_during_run got=%b want=1", held); end
    checks++; if (out_lo !== 32'd10 || out_hi !== 32'd0) begin
      failures++; $display("FAIL b2b_second got=%0d/%0d want=10/0", out_lo, out_hi);
    end
  endtask

  task automatic test_reset_mid();
    int lat, bc;
    bit held;
    bit saw_done;
    start_op(32'd5000, 32'd7, 1'b0, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b want=0", busy); end
    checks++; if (out_lo !== '0 || out_hi !== '0) begin
      failures++; $display("FAIL rstmid_clear got=%h/%h want=0/0", out_lo, out_hi);
    end
    saw_done = 1'b0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (done) saw_done = 1'b1;
    end
    checks++; if (saw_done !== 1'b0) begin failures++; $display("FAIL rstmid_no_done got=%b want=0", saw_done); end
    start_op(32'hFFFF_FFF7, 32'd4, 1'b1, 1'b0);
    wait_done(0, lat, bc, held);
    checks++; if (lat !== LAT || out_lo !== 32'hFFFF_FFFE || out_hi !== 32'hFFFF_FFFF) begin
      failures++; $display("FAIL rstmid_restart got lat=%0d %h/%h want lat=%0d fffffffe/ffffffff", lat, out_lo, out_hi, LAT);
    end
  endtask

  task automatic test_random();
    int lat, bc;
    bit held;
    logic [W-1:0] a, b, q, r;
    logic s;
    bit now;
    now = 1'b0;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = W'($urandom_range(1, 20));
        1:       b = '0;
        2:       b = $urandom;
        default: b = -W'($urandom_range(1, 20));
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      s = 1'($urandom_range(0, 1));
      model(a, b, s, q, r);
      start_op(a, b, s, now);
      wait_done(0, lat, bc, held);
      checks++; if (lat !== LAT || out_lo !== q || out_hi !== r) begin
        failures++;
        $display("FAIL rand%0d a=%h b=%h s=%b got lat=%0d %h/%h want lat=%0d %h/%h",
                 i, a, b, s, lat, out_lo, out_hi, LAT, q, r);
      end
      now = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_reject();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
